reorder_buffer_param: RTL and testbench

Parametrised in-order retirement buffer for the out-of-order core. It sits between dispatch, the execution writeback buses and the architectural register file, branch predictor and return-address stack. It generalises the 32-entry, 3-writeback ROB in three ways: configurable depth and writeback-port count, an exact occupancy counter that uses every slot, and a sticky overflow/underflow error flag.

---
 rtl/reorder_buffer_param.sv | 231 +++++++++++++++++++++++
 tb/tb_reorder_buffer_param.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_param.sv
// Parametrised in-order retirement buffer: allocate at tail, writeback by id, retire one ready entry per cycle.
// Build option: define ROB_BYPASS_EN to forward same-cycle writeback values onto the operand query ports.
module reorder_buffer_param #(
    parameter int DEPTH    = 32,
    parameter int ID_W     = $clog2(DEPTH),
    parameter int WB_PORTS = 3,
    parameter int ADDR_W   = 17
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     append_en,
    input  logic [2:0]               append_type,
    input  logic                     append_c_instruction,
    input  logic [4:0]               append_dest_regid,
    input  logic [ADDR_W-1:0]        append_address_info,
    input  logic [ADDR_W-1:0]        append_address_predict,
    input  logic                     append_branch_prediction,
    input  logic [ADDR_W-1:0]        append_address,

    input  logic [WB_PORTS-1:0]      wb_en,
    input  logic [WB_PORTS*ID_W-1:0] wb_id,
    input  logic [WB_PORTS*32-1:0]   wb_val,

    input  logic [ID_W-1:0]          query_id1,
    input  logic [ID_W-1:0]          query_id2,
    output logic                     query_dep1,
    output logic                     query_dep2,
    output logic [31:0]              query_val1,
    output logic [31:0]              query_val2,

    output logic [ID_W-1:0]          next_id,
    output logic                     full,
    output logic [ID_W:0]            count,
    output logic                     err,

    output logic                     redirect_en,
    output logic [ADDR_W-1:0]        redirect_pc,
    output logic                     predictor_input_en,
    output logic [ADDR_W-1:0]        predictor_addr,
    output logic                     branch_take,
    output logic                     stack_input_en,
    output logic                     stack_push_mode,
    output logic [ADDR_W-1:0]        stack_push_addr,
    output logic                     commit_en,
    output logic                     register_writeback_en,
    output logic [4:0]               register_writeback_id,
    output logic [ID_W-1:0]          register_writeback_dependency,
    output logic [31:0]              register_writeback_val
);

    typedef enum logic [2:0] {
        T_ALU    = 3'd0,
        T_STORE  = 3'd1,
        T_BRANCH = 3'd2,
        T_JAL    = 3'd3,
        T_JALR   = 3'd4
    } rob_type_e;

    localparam int CNT_W = ID_W + 1;

    logic [2:0]        ent_type  [DEPTH];
    logic              ent_c     [DEPTH];
    logic [4:0]        ent_dest  [DEPTH];
    logic [ADDR_W-1:0] ent_addr  [DEPTH];
    logic [31:0]       ent_val1  [DEPTH];
    logic [ADDR_W-1:0] ent_val2  [DEPTH];
    logic              ent_pred  [DEPTH];
    logic [DEPTH-1:0]  ent_ready;

    logic [ID_W-1:0]   head;
    logic [ID_W-1:0]   tail;
    logic              do_commit;
    logic              do_append;
    logic              overflow;
    rob_type_e         head_type;

    assign head_type = rob_type_e'(ent_type[head]);
    assign do_commit = !redirect_en && (count != '0) && ent_ready[head];
    assign overflow  = append_en && !redirect_en && (count == CNT_W'(DEPTH)) && !do_commit;
    assign do_append = append_en && !redirect_en && !overflow;

    assign next_id = tail + ID_W'(append_en);
    assign full    = ({1'b0, count} + (CNT_W+1)'(append_en)) >= (CNT_W+1)'(DEPTH - 1);

    // Entry storage; append is applied after writebacks so a fresh tail entry is never clobbered.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_ready <= '0;
        end else begin
            for (int unsigned k = 0; k < WB_PORTS; k++) begin
                if (wb_en[k]) begin
                    ent_ready[wb_id[k*ID_W +: ID_W]] <= 1'b1;
                    ent_val1[wb_id[k*ID_W +: ID_W]]  <= wb_val[k*32 +: 32];
                    if (ent_type[wb_id[k*ID_W +: ID_W]] == T_JALR)
                        ent_pred[wb_id[k*ID_W +: ID_W]] <=
                            (wb_val[k*32 +: ADDR_W] == ent_val1[wb_id[k*ID_W +: ID_W]][ADDR_W-1:0]);
                end
            end
            if (do_append) begin
                ent_type[tail]  <= append_type;
                ent_c[tail]     <= append_c_instruction;
                ent_dest[tail]  <= append_dest_regid;
                ent_addr[tail]  <= append_address;
                ent_val1[tail]  <= 32'(append_address_predict);
                ent_val2[tail]  <= append_address_info;
                ent_pred[tail]  <= append_branch_prediction;
                ent_ready[tail] <= (append_type == T_STORE) || (append_type == T_JAL);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head                  <= '0;
            tail                  <= '0;
            count                 <= '0;
            err                   <= 1'b0;
            redirect_en           <= 1'b0;
            predictor_input_en    <= 1'b0;
            stack_input_en        <= 1'b0;
            commit_en             <= 1'b0;
            register_writeback_en <= 1'b0;
        end else if (redirect_en) begin
            head                  <= '0;
            tail                  <= '0;
            count                 <= '0;
            redirect_en           <= 1'b0;
            predictor_input_en    <= 1'b0;
            stack_input_en        <= 1'b0;
            commit_en             <= 1'b0;
            register_writeback_en <= 1'b0;
        end else begin
            redirect_en           <= 1'b0;
            predictor_input_en    <= 1'b0;
            stack_input_en        <= 1'b0;
            commit_en             <= 1'b0;
            register_writeback_en <= 1'b0;
            if (do_append)
                tail <= tail + ID_W'(1);
            if (overflow)
                err <= 1'b1;
            if (do_commit) begin
                head                          <= head + ID_W'(1);
                register_writeback_id         <= ent_dest[head];
                register_writeback_dependency <= head;
                case (head_type)
                    T_ALU: begin
                        register_writeback_en  <= (ent_dest[head] != 5'd0);
                        register_writeback_val <= ent_val1[head];
                    end
                    T_STORE: begin
                        commit_en <= 1'b1;
                    end
                    T_BRANCH: begin
                        predictor_input_en <= 1'b1;
                        predictor_addr     <= ent_addr[head];
                        branch_take        <= ent_val1[head][0];
                        redirect_en        <= (ent_pred[head] != ent_val1[head][0]);
                        redirect_pc        <= ent_val1[head][0] ? ent_val2[head]
                                              : ent_addr[head] + (ent_c[head] ? ADDR_W'(2) : ADDR_W'(4));
                    end
                    T_JAL: begin
                        register_writeback_en  <= (ent_dest[head] != 5'd0);
                        register_writeback_val <= 32'(ent_val2[head]);
                        stack_input_en         <= (ent_dest[head] != 5'd0);
                        stack_push_mode        <= 1'b1;
                        stack_push_addr        <= ent_val2[head];
                    end
                    T_JALR: begin
                        register_writeback_en  <= (ent_dest[head] != 5'd0);
                        register_writeback_val <= 32'(ent_val2[head]);
                        stack_input_en         <= 1'b1;
                        stack_push_mode        <= 1'b0;
                        if (!ent_pred[head]) begin
                            redirect_en <= 1'b1;
                            redirect_pc <= ent_val1[head][ADDR_W-1:0];
                        end
                    end
                    default: ;
                endcase
            end
            count <= count + CNT_W'(do_append) - CNT_W'(do_commit);
        end
    end

    logic [ID_W-1:0] q_id  [2];
    logic            q_dep [2];
    logic [31:0]     q_val [2];
    logic            q_hit;

    assign q_id[0]    = query_id1;
    assign q_id[1]    = query_id2;
    assign query_dep1 = q_dep[0];
    assign query_dep2 = q_dep[1];
    assign query_val1 = q_val[0];
    assign query_val2 = q_val[1];

    always_comb begin
        q_hit = 1'b0;
        for (int unsigned q = 0; q < 2; q++) begin
            q_dep[q] = 1'b1;
            q_val[q] = '0;
            q_hit    = 1'b0;
            if (append_en && (q_id[q] == tail)) begin
                q_dep[q] = (append_type != T_JAL);
                q_val[q] = 32'(append_address_info);
            end else if (ent_ready[q_id[q]]) begin
                q_dep[q] = 1'b0;
                q_val[q] = (ent_type[q_id[q]] == T_JAL) ? 32'(ent_val2[q_id[q]]) : ent_val1[q_id[q]];
            end
`ifdef ROB_BYPASS_EN
            else begin
                // Lowest-index matching writeback port is forwarded.
                for (int unsigned k = 0; k < WB_PORTS; k++) begin
                    if (!q_hit && wb_en[k] && (wb_id[k*ID_W +: ID_W] == q_id[q])) begin
                        q_hit    = 1'b1;
                        q_dep[q] = 1'b0;
                        q_val[q] = wb_val[k*32 +: 32];
                    end
                end
            end
`else
            else begin
                q_dep[q] = 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reorder_buffer_param.sv
// Directed bench for reorder_buffer_param at DEPTH=8, three writeback ports, 17-bit addresses.
module tb_reorder_buffer_param;

    localparam logic [2:0] T_ALU    = 3'd0;
    localparam logic [2:0] T_STORE  = 3'd1;
    localparam logic [2:0] T_BRANCH = 3'd2;
    localparam logic [2:0] T_JAL    = 3'd3;
    localparam logic [2:0] T_JALR   = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        append_en;
    logic [2:0]  append_type;
    logic        append_c_instruction;
    logic [4:0]  append_dest_regid;
    logic [16:0] append_address_info;
    logic [16:0] append_address_predict;
    logic        append_branch_prediction;
    logic [16:0] append_address;
    logic [2:0]  wb_en;
    logic [8:0]  wb_id;
    logic [95:0] wb_val;
    logic [2:0]  query_id1, query_id2;
    logic        query_dep1, query_dep2;
    logic [31:0] query_val1, query_val2;
    logic [2:0]  next_id;
    logic        full;
    logic [3:0]  count;
    logic        err;
    logic        redirect_en;
    logic [16:0] redirect_pc;
    logic        predictor_input_en;
    logic [16:0] predictor_addr;
    logic        branch_take;
    logic        stack_input_en;
    logic        stack_push_mode;
    logic [16:0] stack_push_addr;
    logic        commit_en;
    logic        register_writeback_en;
    logic [4:0]  register_writeback_id;
    logic [2:0]  register_writeback_dependency;
    logic [31:0] register_writeback_val;

    int n_checks = 0;
    int n_fail   = 0;

    reorder_buffer_param #(.DEPTH(8), .WB_PORTS(3), .ADDR_W(17)) dut (
        .clk(clk), .rst(rst),
        .append_en(append_en), .append_type(append_type),
        .append_c_instruction(append_c_instruction), .append_dest_regid(append_dest_regid),
        .append_address_info(append_address_info), .append_address_predict(append_address_predict),
        .append_branch_prediction(append_branch_prediction), .append_address(append_address),
        .wb_en(wb_en), .wb_id(wb_id), .wb_val(wb_val),
        .query_id1(query_id1), .query_id2(query_id2),
        .query_dep1(query_dep1), .query_dep2(query_dep2),
        .query_val1(query_val1), .query_val2(query_val2),
        .next_id(next_id), .full(full), .count(count), .err(err),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .predictor_input_en(predictor_input_en), .predictor_addr(predictor_addr),
        .branch_take(branch_take), .stack_input_en(stack_input_en),
        .stack_push_mode(stack_push_mode), .stack_push_addr(stack_push_addr),
        .commit_en(commit_en), .register_writeback_en(register_writeback_en),
        .register_writeback_id(register_writeback_id),
        .register_writeback_dependency(register_writeback_dependency),
        .register_writeback_val(register_writeback_val)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        append_en = 1'b0;
        wb_en     = '0;
    endtask

    task automatic set_append(input logic [2:0] t, input logic c, input logic [4:0] dest,
                              input logic [16:0] info, input logic [16:0] pred_addr,
                              input logic bp, input logic [16:0] pc);
        append_en                = 1'b1;
        append_type              = t;
        append_c_instruction     = c;
        append_dest_regid        = dest;
        append_address_info      = info;
        append_address_predict   = pred_addr;
        append_branch_prediction = bp;
        append_address           = pc;
    endtask

    task automatic drive_wb(input int unsigned port, input logic [2:0] id, input logic [31:0] val);
        wb_en[port]            = 1'b1;
        wb_id[port*3 +: 3]     = id;
        wb_val[port*32 +: 32]  = val;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        set_append(T_ALU, 1'b0, 5'd0, 17'h0, 17'h0, 1'b0, 17'h0);
        append_en = 1'b0;
        wb_id = '0;
        wb_val = '0;
        query_id1 = '0;
        query_id2 = '0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        check_eq("reset_count", 32'(count), 32'd0);
        check_eq("reset_err", 32'(err), 32'd0);
        check_eq("reset_full", 32'(full), 32'd0);
        check_eq("reset_redirect", 32'(redirect_en), 32'd0);
        check_eq("reset_commit", 32'(commit_en), 32'd0);
        check_eq("reset_rwb_en", 32'(register_writeback_en), 32'd0);
        check_eq("reset_next_id", 32'(next_id), 32'd0);

        // In-order retire: id1 written back before id0
        set_append(T_ALU, 1'b0, 5'd5, 17'h0, 17'h0, 1'b0, 17'h10);
        settle();
        check_eq("next_id_with_append", 32'(next_id), 32'd1);
        tick();
        set_append(T_ALU, 1'b0, 5'd6, 17'h0, 17'h0, 1'b0, 17'h14);
        tick();
        idle(); drive_wb(0, 3'd1, 32'h22);
        tick();
        check_eq("basic_count2", 32'(count), 32'd2);
        check_eq("basic_no_early_retire", 32'(register_writeback_en), 32'd0);
        idle(); drive_wb(0, 3'd0, 32'h11);
        tick();
        check_eq("basic_wb_edge_no_retire", 32'(register_writeback_en), 32'd0);
        idle();
        tick();
        check_eq("basic_x5_en", 32'(register_writeback_en), 32'd1);
        check_eq("basic_x5_id", 32'(register_writeback_id), 32'd5);
        check_eq("basic_x5_val", register_writeback_val, 32'h11);
        check_eq("basic_x5_dep", 32'(register_writeback_dependency), 32'd0);
        tick();
        check_eq("basic_x6_en", 32'(register_writeback_en), 32'd1);
        check_eq("basic_x6_id", 32'(register_writeback_id), 32'd6);
        check_eq("basic_x6_val", register_writeback_val, 32'h22);
        check_eq("basic_x6_dep", 32'(register_writeback_dependency), 32'd1);
        check_eq("basic_empty", 32'(count), 32'd0);
        tick();
        check_eq("basic_pulse_drop", 32'(register_writeback_en), 32'd0);

        // Query: ids 2 and 3 pending, port 2 writes id3 this cycle
        set_append(T_ALU, 1'b0, 5'd7, 17'h0, 17'h0, 1'b0, 17'h18);
        tick();
        set_append(T_ALU, 1'b0, 5'd8, 17'h0, 17'h0, 1'b0, 17'h1c);
        tick();
        idle(); drive_wb(2, 3'd3, 32'hDEAD);
        query_id1 = 3'd3; query_id2 = 3'd2;
        settle();
`ifdef ROB_BYPASS_EN
        check_eq("query_bypass_dep", 32'(query_dep1), 32'd0);
        check_eq("query_bypass_val", query_val1, 32'hDEAD);
`else
        check_eq("query_nobypass_dep", 32'(query_dep1), 32'd1);
`endif
        check_eq("query_unready_dep", 32'(query_dep2), 32'd1);
        tick();
        idle();
        settle();
        check_eq("query_ready_dep", 32'(query_dep1), 32'd0);
        check_eq("query_ready_val", query_val1, 32'hDEAD);
        set_append(T_ALU, 1'b0, 5'd9, 17'h1234, 17'h0, 1'b0, 17'h20);
        query_id2 = 3'd4;
        settle();
        check_eq("query_tail_alu_dep", 32'(query_dep2), 32'd1);
        check_eq("query_tail_val", query_val2, 32'h1234);
        append_type = T_JAL;
        settle();
        check_eq("query_tail_jal_dep", 32'(query_dep2), 32'd0);
        idle(); drive_wb(0, 3'd2, 32'h77);
        tick();
        idle();
        tick();
        check_eq("q_retire_id", 32'(register_writeback_id), 32'd7);
        check_eq("q_retire_val", register_writeback_val, 32'h77);
        check_eq("q_retire_count", 32'(count), 32'd1);
        tick();
        check_eq("q_retire2_val", register_writeback_val, 32'hDEAD);
        check_eq("q_retire2_dep", 32'(register_writeback_dependency), 32'd3);

        // Compressed branch at 0x100 predicted taken, resolves not-taken
        set_append(T_BRANCH, 1'b1, 5'd0, 17'h300, 17'h0, 1'b1, 17'h100);
        tick();
        idle(); drive_wb(0, 3'd4, 32'h0);
        tick();
        idle();
        tick();
        check_eq("br_redirect", 32'(redirect_en), 32'd1);
        check_eq("br_redirect_pc", 32'(redirect_pc), 32'h102);
        check_eq("br_pred_en", 32'(predictor_input_en), 32'd1);
        check_eq("br_pred_addr", 32'(predictor_addr), 32'h100);
        check_eq("br_take", 32'(branch_take), 32'd0);
        set_append(T_ALU, 1'b0, 5'd3, 17'h0, 17'h0, 1'b0, 17'h104);
        tick();
        idle();
        settle();
        check_eq("flush_count", 32'(count), 32'd0);
        check_eq("flush_redirect", 32'(redirect_en), 32'd0);
        check_eq("flush_pred_en", 32'(predictor_input_en), 32'd0);
        check_eq("flush_tail", 32'(next_id), 32'd0);

        // jalr mispredicted: predicted 0x200, actual 0x204
        set_append(T_JALR, 1'b0, 5'd1, 17'h150, 17'h200, 1'b0, 17'h14c);
        tick();
        idle(); drive_wb(1, 3'd0, 32'h204);
        tick();
        idle();
        tick();
        check_eq("jalr_mp_stack_en", 32'(stack_input_en), 32'd1);
        check_eq("jalr_mp_pop", 32'(stack_push_mode), 32'd0);
        check_eq("jalr_mp_redirect", 32'(redirect_en), 32'd1);
        check_eq("jalr_mp_pc", 32'(redirect_pc), 32'h204);
        check_eq("jalr_mp_link", register_writeback_val, 32'h150);
        tick();
        check_eq("jalr_flush_stack", 32'(stack_input_en), 32'd0);
        check_eq("jalr_flush_count", 32'(count), 32'd0);

        // jalr predicted correctly
        set_append(T_JALR, 1'b0, 5'd1, 17'h150, 17'h200, 1'b0, 17'h14c);
        tick();
        idle(); drive_wb(1, 3'd0, 32'h200);
        tick();
        idle();
        tick();
        check_eq("jalr_ok_redirect", 32'(redirect_en), 32'd0);
        check_eq("jalr_ok_stack_en", 32'(stack_input_en), 32'd1);
        check_eq("jalr_ok_link", register_writeback_val, 32'h150);

        // jal pushes only with nonzero dest; store pulses commit_en
        set_append(T_JAL, 1'b0, 5'd1, 17'h88, 17'h0, 1'b0, 17'h84);
        tick();
        idle();
        tick();
        check_eq("jal_push_en", 32'(stack_input_en), 32'd1);
        check_eq("jal_push_mode", 32'(stack_push_mode), 32'd1);
        check_eq("jal_push_addr", 32'(stack_push_addr), 32'h88);
        check_eq("jal_link", register_writeback_val, 32'h88);
        check_eq("jal_dep", 32'(register_writeback_dependency), 32'd1);
        set_append(T_JAL, 1'b0, 5'd0, 17'h90, 17'h0, 1'b0, 17'h8c);
        tick();
        idle();
        tick();
        check_eq("jal_x0_no_push", 32'(stack_input_en), 32'd0);
        check_eq("jal_x0_no_wb", 32'(register_writeback_en), 32'd0);
        set_append(T_STORE, 1'b0, 5'd0, 17'h0, 17'h0, 1'b0, 17'h90);
        tick();
        idle();
        tick();
        check_eq("store_commit", 32'(commit_en), 32'd1);
        tick();
        check_eq("store_commit_pulse", 32'(commit_en), 32'd0);

        // Fill with unready ALU entries
        for (int i = 0; i < 6; i++) begin
            set_append(T_ALU, 1'b0, 5'(i + 1), 17'h0, 17'h0, 1'b0, 17'h0);
            tick();
        end
        idle();
        settle();
        check_eq("fill_count6", 32'(count), 32'd6);
        check_eq("fill_not_full6", 32'(full), 32'd0);
        set_append(T_ALU, 1'b0, 5'd7, 17'h0, 17'h0, 1'b0, 17'h0);
        settle();
        check_eq("fill_full_6_plus_append", 32'(full), 32'd1);
        tick();
        idle();
        settle();
        check_eq("fill_count7", 32'(count), 32'd7);
        check_eq("fill_full7", 32'(full), 32'd1);
        set_append(T_ALU, 1'b0, 5'd8, 17'h0, 17'h0, 1'b0, 17'h0);
        tick();
        check_eq("fill_count8", 32'(count), 32'd8);
        check_eq("fill_no_err", 32'(err), 32'd0);
        tick();
        check_eq("overflow_count", 32'(count), 32'd8);
        check_eq("overflow_err", 32'(err), 32'd1);
        idle();
        tick();
        check_eq("err_sticky", 32'(err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check_eq("midreset_count", 32'(count), 32'd0);
        check_eq("midreset_err", 32'(err), 32'd0);

        // Wrap: append/commit pairs, one entry in flight
        for (int i = 0; i < 20; i++) begin
            set_append(T_JAL, 1'b0, 5'((i % 31) + 1), 17'(32'h40 + i * 4), 17'h0, 1'b0, 17'h0);
            tick();
            check_eq("wrap_count", 32'(count), 32'd1);
            if (i > 0) begin
                check_eq("wrap_val", register_writeback_val, 32'(32'h40 + (i - 1) * 4));
                check_eq("wrap_dep", 32'(register_writeback_dependency), 32'((i - 1) % 8));
            end
        end
        idle();
        tick();
        check_eq("wrap_last_val", register_writeback_val, 32'(32'h40 + 19 * 4));
        check_eq("wrap_last_dep", 32'(register_writeback_dependency), 32'd3);
        check_eq("wrap_empty", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
